frame_uart_tx: RTL and testbench

- Downstream stage of the response packer: it serialises the three response bytes onto the UART line to the PC.
- On a one-cycle START pulse it latches BYTE1..BYTE3 and transmits them back-to-back as 8N1 frames, LSB first, in order BYTE1, BYTE2, BYTE3.
- It reports BUSY while sending and pulses DONE when the third stop bit ends, so the main state machine can return to idle.

---
 rtl/frame_uart_tx.sv | 213 +++++++++++++++++++++
 tb/tb_frame_uart_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/frame_uart_tx.sv
// -----------------------------------------------------------------------------
// frame_uart_tx
//
// Serialises the three response bytes from the response packer onto the UART
// line to the PC. A one-cycle start request latches byte1..byte3 and the block
// sends them back-to-back as 8N1 frames, LSB first, in the order byte1, byte2,
// byte3. busy is high while a transfer is in progress. done pulses for one
// cycle once the third stop bit has ended.
//
// Parameters:
//   CLKS_PER_BIT  system clock cycles per UART bit (legal range 2..65535)
//
// Ports:
//   clk    in   system clock; all logic on the rising edge
//   reset  in   synchronous, active-high reset; overrides everything
//   start  in   one-cycle request, sampled only while idle
//   byte1  in   first byte  (response code)
//   byte2  in   second byte (integer part or code)
//   byte3  in   third byte  (fractional part or code)
//   tx     out  UART serial line, idle high, driven from a register
//   busy   out  high while a 3-byte transfer is in progress
//   done   out  one-cycle pulse at the end of the transfer
// -----------------------------------------------------------------------------
module frame_uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte1,
  input  logic [7:0] byte2,
  input  logic [7:0] byte3,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // The counter only has to reach CLKS_PER_BIT-1, so ceil(log2) bits suffice.
  // The legal range starts at 2, which keeps the width at least 1.
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    DONE_ST   = 3'd4
  } state_t;

  // Current and next-state registers.
  state_t            state,    state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_cnt,  bit_next;
  logic [1:0]        byte_idx, idx_next;
  logic [23:0]       shadow,   shadow_next;
  logic              tx_next, busy_next, done_next;

  // Helper signals.
  logic [7:0]        cur_byte;
  logic [2:0]        bit_inc;
  logic              bit_end;

  // Byte being sent. Index 3 cannot be reached; the state logic below sends
  // the block back to IDLE if it ever is.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx)
      2'd0:    cur_byte = shadow[7:0];
      2'd1:    cur_byte = shadow[15:8];
      2'd2:    cur_byte = shadow[23:16];
      default: cur_byte = 8'h00;
    endcase
  end

  assign bit_inc = bit_cnt + 3'd1;
  assign bit_end = (baud_cnt == BAUD_LAST);

  // ---------------------------------------------------------------------------
  // State register. All outputs are registered, so tx, busy and done change on
  // the same edge as the state they belong to.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and the order of statements does not
  // matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      byte_idx <= 2'd0;
      shadow   <= 24'h0;   // latched data is discarded on reset
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      byte_idx <= idx_next;
      shadow   <= shadow_next;
      tx       <= tx_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. tx_next is the line level of the bit
  // that starts at the coming edge. That is why the first start bit appears
  // one cycle after the start request.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt + BAUD_ONE;
    bit_next    = bit_cnt;
    idx_next    = byte_idx;
    shadow_next = shadow;
    tx_next     = tx;
    busy_next   = busy;
    done_next   = 1'b0;

    case (state)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        baud_next = '0;
        if (start) begin
          state_next  = START_BIT;
          shadow_next = {byte3, byte2, byte1};
          idx_next    = 2'd0;
          bit_next    = 3'd0;
          tx_next     = 1'b0;
          busy_next   = 1'b1;
        end
      end

      START_BIT: begin
        if (bit_end) begin
          state_next = DATA_BITS;
          baud_next  = '0;
          bit_next   = 3'd0;
          tx_next    = cur_byte[0];
        end
      end

      DATA_BITS: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) begin
            state_next = STOP_BIT;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_inc;
            tx_next  = cur_byte[bit_inc];
          end
        end
      end

      STOP_BIT: begin
        if (bit_end) begin
          baud_next = '0;
          if (byte_idx < 2'd2) begin
            // The next start bit follows the stop bit directly, with no idle
            // gap between frames.
            state_next = START_BIT;
            idx_next   = byte_idx + 2'd1;
            tx_next    = 1'b0;
          end else begin
            state_next = DONE_ST;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
      end

      DONE_ST: begin
        // A start request seen here is dropped. The next request can only be
        // taken in IDLE, one cycle later.
        state_next = IDLE;
        baud_next  = '0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
        baud_next  = '0;
        bit_next   = 3'd0;
        idx_next   = 2'd0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase

    // An out-of-range byte index cannot happen in normal operation. If it
    // does, abandon the transfer rather than send an undefined byte.
    if (state != IDLE && byte_idx == 2'd3) begin
      state_next = IDLE;
      baud_next  = '0;
      bit_next   = 3'd0;
      idx_next   = 2'd0;
      tx_next    = 1'b1;
      busy_next  = 1'b0;
      done_next  = 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_frame_uart_tx
//
// Directed testbench for frame_uart_tx with CLKS_PER_BIT = 4. Inputs are driven
// and outputs sampled on the falling clock edge, away from the active edge.
// Every expected waveform and byte is built here from the values that were
// sent.
// -----------------------------------------------------------------------------
module tb_frame_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] byte1, byte2, byte3;
  logic       tx, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  frame_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .byte1 (byte1),
    .byte2 (byte2),
    .byte3 (byte3),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle. On return the bench sits on the falling edge
  // just after the edge that sampled start.
  task automatic pulse_start(input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input string tag);
    @(negedge clk);
    check({tag, "_idle_tx"}, tx, 1);
    byte1 = b1; byte2 = b2; byte3 = b3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follow one transfer from offset 0, the cycle of the first falling tx
  // edge, through offset 121, the first idle cycle after DONE_ST. At
  // poke_cycle the task drives poke_start and poke_byte onto the inputs and
  // drops start again one cycle later. With chain set it raises start in the
  // DONE_ST cycle and leaves it high on return.
  task automatic observe(input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                         input string tag, input int poke_cycle, input logic poke_start,
                         input logic [7:0] poke_byte, input logic chain);
    logic [7:0]   exp_b[3];
    logic [29:0]  exp_bits;
    logic [119:0] samples;
    logic [7:0]   dec;
    int           wave_err = 0;
    int           busy_err = 0;
    int           done_err = 0;

    exp_b = '{e1, e2, e3};
    for (int f = 0; f < 3; f++) begin
      exp_bits[f*10] = 1'b0;
      for (int k = 0; k < 8; k++) exp_bits[f*10+1+k] = exp_b[f][k];
      exp_bits[f*10+9] = 1'b1;
    end

    check({tag, "_first_fall"}, tx, 0);
    for (int i = 0; i < 30*CPB; i++) begin
      samples[i] = tx;
      if (tx !== exp_bits[i/CPB]) wave_err++;
      if (busy !== 1'b1) busy_err++;
      if (done !== 1'b0) done_err++;
      if (i == poke_cycle) begin
        byte1 = poke_byte; byte2 = poke_byte; byte3 = poke_byte;
        start = poke_start;
      end else if (i == poke_cycle + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end

    check({tag, "_wave_errs"}, wave_err, 0);
    check({tag, "_busy_errs"}, busy_err, 0);
    check({tag, "_early_done"}, done_err, 0);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) dec[k] = samples[(f*10+1+k)*CPB + CPB/2];
      check($sformatf("%s_byte%0d", tag, f+1), dec, exp_b[f]);
    end

    // DONE_ST cycle: exactly 120 cycles after the first fall
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_tx"}, tx, 1);
    if (chain) begin
      byte1 = poke_byte; byte2 = poke_byte; byte3 = poke_byte;
      start = 1'b1;
    end
    @(negedge clk);
    check({tag, "_after_done"}, done, 0);
    check({tag, "_after_busy"}, busy, 0);
    check({tag, "_after_tx"}, tx, 1);
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0;
    byte1 = 8'h00; byte2 = 8'h00; byte3 = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_20", bad, 0);

    // Nominal frame
    pulse_start(8'h09, 8'h19, 8'h05, "nom");
    observe(8'h09, 8'h19, 8'h05, "nom", -1, 1'b0, 8'h00, 1'b0);

    // Inputs change to 0xFF one cycle after start
    pulse_start(8'h09, 8'h19, 8'h05, "stab");
    observe(8'h09, 8'h19, 8'h05, "stab", 0, 1'b0, 8'hFF, 1'b0);

    // Start at cycle 50 of a transfer is ignored and not queued
    pulse_start(8'h09, 8'h19, 8'h05, "ign");
    observe(8'h09, 8'h19, 8'h05, "ign", 50, 1'b1, 8'h1F, 1'b0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("ign_no_queue", bad, 0);

    // Reset during a data bit of byte2 (data bits 11..18 span cycles 44..75)
    pulse_start(8'h09, 8'h19, 8'h05, "mid");
    repeat (50) @(negedge clk);
    check("mid_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    bad = 0;
    repeat (130) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("mid_quiet", bad, 0);
    pulse_start(8'h07, 8'h07, 8'h07, "rec");
    observe(8'h07, 8'h07, 8'h07, "rec", -1, 1'b0, 8'h00, 1'b0);

    // Back-to-back: start is held high in DONE_ST and in the following IDLE
    // cycle. observe() checks that tx and busy stay idle in that IDLE cycle.
    pulse_start(8'h5A, 8'hC3, 8'h81, "b2b_a");
    observe(8'h5A, 8'hC3, 8'h81, "b2b_a", -1, 1'b0, 8'h3C, 1'b1);
    @(negedge clk);
    start = 1'b0;
    observe(8'h3C, 8'h3C, 8'h3C, "b2b_b", -1, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
